// File: rtl/alu_pipe_if.sv
// Operand-issue / result-consumer bundle for alu_pipe.
// Both channels use valid/ready: a word moves on a rising edge where valid and ready are both high;
// once raised, valid and its payload stay stable until that transfer, and ready may depend combinationally on the far side.
interface alu_pipe_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       opcode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             flag_c;
  logic             flag_z;
  logic             flag_n;
  logic             flag_v;
  logic [CNT_W-1:0] res_cnt;

  modport master (
    output in_valid, opcode, a, b, out_ready,
    input  in_ready, out_valid, out, flag_c, flag_z, flag_n, flag_v, res_cnt
  );

  modport slave (
    input  in_valid, opcode, a, b, out_ready,
    output in_ready, out_valid, out, flag_c, flag_z, flag_n, flag_v, res_cnt
  );
endinterface

// File: rtl/alu_pipe.sv
// Two-stage stallable ALU: S1 holds operands, S2 holds result + flags; saturating result counter.
// Optional feature macro: ALU_SAT_EN (plus/minus clamp instead of wrapping).
module alu_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  alu_pipe_if.slave  bus
);

  typedef enum logic [2:0] {
    OP_PLUS = 3'd0,
    OP_MINUS = 3'd1,
    OP_BAND = 3'd2,
    OP_BOR = 3'd3,
    OP_UNEG = 3'd4,
    OP_BXOR = 3'd5,
    OP_SHL = 3'd6,
    OP_SHR = 3'd7
  } op_e;

  logic             s1_v;
  op_e              s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s2_v;
  logic [WIDTH-1:0] s2_out;
  logic             s2_c, s2_z, s2_n, s2_v_flag;
  logic [CNT_W-1:0] cnt;

  logic             s1_adv;
  logic             s2_adv;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   dif;
  logic [WIDTH-1:0] res;
  logic             res_c, res_v;

  // An empty stage, or one whose contents move on this edge, can always load.
  assign s2_adv = ~s2_v | bus.out_ready;
  assign s1_adv = ~s1_v | s2_adv;

  always_comb begin
    res   = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    sum   = {1'b0, s1_a} + {1'b0, s1_b};
    dif   = {1'b0, s1_a} - {1'b0, s1_b};
    case (s1_op)
      OP_PLUS: begin
        res   = sum[WIDTH-1:0];
        res_c = sum[WIDTH];
        res_v = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) & (sum[WIDTH-1] != s1_a[WIDTH-1]);
`ifdef ALU_SAT_EN
        if (sum[WIDTH]) begin
          res   = '1;
          res_v = 1'b0;
        end
`endif
      end
      OP_MINUS: begin
        res   = dif[WIDTH-1:0];
        res_c = dif[WIDTH];
        res_v = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) & (dif[WIDTH-1] != s1_a[WIDTH-1]);
`ifdef ALU_SAT_EN
        if (dif[WIDTH]) begin
          res   = '0;
          res_v = 1'b0;
        end
`endif
      end
      OP_BAND: res = s1_a & s1_b;
      OP_BOR:  res = s1_a | s1_b;
      OP_UNEG: res = ~s1_a;
      OP_BXOR: res = s1_a ^ s1_b;
      OP_SHL: begin
        res   = {s1_a[WIDTH-2:0], 1'b0};
        res_c = s1_a[WIDTH-1];
      end
      OP_SHR: begin
        res   = {1'b0, s1_a[WIDTH-1:1]};
        res_c = s1_a[0];
      end
      default: res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v      <= 1'b0;
      s1_op     <= OP_PLUS;
      s1_a      <= '0;
      s1_b      <= '0;
      s2_v      <= 1'b0;
      s2_out    <= '0;
      s2_c      <= 1'b0;
      s2_z      <= 1'b0;
      s2_n      <= 1'b0;
      s2_v_flag <= 1'b0;
      cnt       <= '0;
    end else begin
      if (s1_adv) begin
        s1_v <= bus.in_valid;
        if (bus.in_valid) begin
          s1_op <= op_e'(bus.opcode);
          s1_a  <= bus.a;
          s1_b  <= bus.b;
        end
      end
      if (s2_adv) begin
        s2_v <= s1_v;
        if (s1_v) begin
          s2_out    <= res;
          s2_c      <= res_c;
          s2_z      <= (res == '0);
          s2_n      <= res[WIDTH-1];
          s2_v_flag <= res_v;
        end
      end
      if (s2_v & bus.out_ready & ~&cnt) cnt <= cnt + CNT_W'(1);
    end
  end

  assign bus.in_ready  = s1_adv;
  assign bus.out_valid = s2_v;
  assign bus.out       = s2_out;
  assign bus.flag_c    = s2_c;
  assign bus.flag_z    = s2_z;
  assign bus.flag_n    = s2_n;
  assign bus.flag_v    = s2_v_flag;
  assign bus.res_cnt   = cnt;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: flag vectors, full-rate stream, stall/drain, async reset, counter saturation.
module tb_alu_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_pipe_if #(.WIDTH(8), .CNT_W(16)) bus ();
  alu_pipe_if #(.WIDTH(8), .CNT_W(2))  cbus ();

  alu_pipe #(.WIDTH(8), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  alu_pipe #(.WIDTH(8), .CNT_W(2))  dut_cnt (.clk(clk), .rst(rst), .bus(cbus));

  int n_assert = 0;
  int n_fail   = 0;
  // Scoreboard entries are {c, z, n, v, out}.
  logic [11:0] exp_q[$];
  logic [11:0] stream_exp [8];
  int          cnt_seq [5];
  int          nxt;
  int          xfers = 0;
  logic        accepted;
  logic        saw_valid;
  logic        saw_ready;
  logic        was_stalled = 1'b0;
  logic [11:0] held;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [11:0] outv();
    return {bus.flag_c, bus.flag_z, bus.flag_n, bus.flag_v, bus.out};
  endfunction

  task automatic drive(input logic [2:0] op, input logic [7:0] av, input logic [7:0] bv);
    bus.in_valid = 1'b1;
    bus.opcode   = op;
    bus.a        = av;
    bus.b        = bv;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  // One clock of the stream scoreboard: observe at negedge, update inputs just after posedge.
  task automatic tick();
    @(negedge clk);
    saw_valid = bus.out_valid;
    saw_ready = bus.in_ready;
    accepted  = bus.in_valid && bus.in_ready;
    if (accepted) exp_q.push_back(stream_exp[nxt]);
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_out", 32'd1, 32'd0);
      else chk("stream_out", outv(), exp_q.pop_front());
      xfers++;
    end
    if (bus.out_valid && !bus.out_ready) begin
      if (was_stalled) chk("stall_hold", outv(), held);
      held        = outv();
      was_stalled = 1'b1;
    end else begin
      was_stalled = 1'b0;
    end
    @(posedge clk);
    #1;
    if (accepted) begin
      nxt++;
      if (nxt < 8) drive(nxt[2:0], 8'hA5, 8'h3C);
      else idle();
    end
  endtask

  task automatic one_op(input string tag, input logic [2:0] op, input logic [7:0] av,
                        input logic [7:0] bv, input logic [11:0] exp_v);
    drive(op, av, bv);
    @(posedge clk);
    #1;
    idle();
    @(negedge clk);
    chk({tag, "_s1_only"}, bus.out_valid, 1'b0);
    @(negedge clk);
    chk({tag, "_valid"}, bus.out_valid, 1'b1);
    chk(tag, outv(), exp_v);
    @(posedge clk);
    #1;
    xfers++;
  endtask

  initial begin
    int run;
    int max_run;
    int acc;
    int ctr;
    logic ready_drop;
    logic stale;
    logic tr;

    stream_exp = '{12'h2E1, 12'h169, 12'h024, 12'h2BD, 12'h05A, 12'h299, 12'h84A, 12'h852};
    cnt_seq    = '{1, 2, 3, 3, 3};
    bus.in_valid = 1'b0; bus.opcode = '0; bus.a = '0; bus.b = '0; bus.out_ready = 1'b0;
    cbus.in_valid = 1'b0; cbus.opcode = '0; cbus.a = '0; cbus.b = '0; cbus.out_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_flags", outv(), 12'h000);
    chk("rst_res_cnt", bus.res_cnt, 16'd0);
    chk("rst_cnt2", cbus.res_cnt, 2'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("in_ready_after_rst", bus.in_ready, 1'b1);

    // Directed flag vectors
    bus.out_ready = 1'b1;
    one_op("plus_7f_01", 3'd0, 8'h7F, 8'h01, 12'h380);
    one_op("minus_80_01", 3'd1, 8'h80, 8'h01, 12'h17F);
`ifdef ALU_SAT_EN
    one_op("minus_05_07", 3'd1, 8'h05, 8'h07, 12'hC00);
    one_op("plus_ff_01", 3'd0, 8'hFF, 8'h01, 12'hAFF);
    one_op("plus_80_80", 3'd0, 8'h80, 8'h80, 12'hAFF);
`else
    one_op("minus_05_07", 3'd1, 8'h05, 8'h07, 12'hAFE);
    one_op("plus_ff_01", 3'd0, 8'hFF, 8'h01, 12'hC00);
    one_op("plus_80_80", 3'd0, 8'h80, 8'h80, 12'hD00);
`endif

    // Full-rate stream of all eight opcodes
    nxt = 0;
    drive(3'd0, 8'hA5, 8'h3C);
    run = 0; max_run = 0; ready_drop = 1'b0;
    for (int k = 0; k < 40 && !(nxt == 8 && exp_q.size() == 0); k++) begin
      tick();
      if (!saw_ready) ready_drop = 1'b1;
      if (saw_valid) begin
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
    end
    chk("stream_done", (nxt == 8 && exp_q.size() == 0), 1'b1);
    chk("stream_consecutive", max_run, 8);
    chk("stream_in_ready", ready_drop, 1'b0);

    // Stall with empty pipe: two accepts then in_ready low, output held
    bus.out_ready = 1'b0;
    nxt = 0;
    drive(3'd0, 8'hA5, 8'h3C);
    tick(); chk("stall_rdy1", saw_ready, 1'b1);
    tick(); chk("stall_rdy2", saw_ready, 1'b1);
    tick(); chk("stall_rdy3", saw_ready, 1'b0);
    tick(); chk("stall_rdy4", saw_ready, 1'b0);
    tick(); chk("stall_rdy5", saw_ready, 1'b0);
    chk("stall_accepts", exp_q.size(), 2);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 40 && !(nxt == 8 && exp_q.size() == 0); k++) tick();
    chk("drain_done", (nxt == 8 && exp_q.size() == 0), 1'b1);
    chk("res_cnt_total", bus.res_cnt, xfers);

    // Asynchronous reset while both stages are full and stalled
    bus.out_ready = 1'b0;
    nxt = 0;
    drive(3'd0, 8'hA5, 8'h3C);
    tick();
    tick();
    chk("pre_rst_full", bus.out_valid, 1'b1);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_out_valid", bus.out_valid, 1'b0);
    chk("async_rst_res_cnt", bus.res_cnt, 16'd0);
    chk("async_rst_out_flags", outv(), 12'h000);
    idle();
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    stale = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) stale = 1'b1;
    end
    chk("no_stale_result", stale, 1'b0);
    chk("post_rst_res_cnt", bus.res_cnt, 16'd0);

    // Saturating 2-bit counter on the second instance
    @(posedge clk);
    #1;
    cbus.out_ready = 1'b1;
    cbus.opcode = 3'd0; cbus.a = 8'h01; cbus.b = 8'h01;
    cbus.in_valid = 1'b1;
    acc = 0; ctr = 0;
    for (int k = 0; k < 20 && ctr < 5; k++) begin
      @(negedge clk);
      if (cbus.in_valid && cbus.in_ready) acc++;
      tr = cbus.out_valid && cbus.out_ready;
      @(posedge clk);
      #1;
      if (acc == 5) cbus.in_valid = 1'b0;
      if (tr) begin
        ctr++;
        chk($sformatf("cnt2_xfer%0d", ctr), cbus.res_cnt, cnt_seq[ctr-1]);
      end
    end
    chk("cnt2_xfers", ctr, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
